// File: rtl/fft_bitrev_loader_if.sv
// ---------------------------------------------------------------------------
// fft_bitrev_loader_if
// Bundles the sample stream handshake and the RAM port A write bus of the
// bit-reversing FFT loader.
//   i_s_data   : input sample ([31:16] real, [15:0] imaginary)
//   i_s_valid  : i_s_data is valid
//   o_s_ready  : loader accepts a sample this cycle
//   o_ram_addr : RAM port A address (bit-reversed sample index)
//   o_ram_data : RAM port A write data
//   o_ram_we   : RAM port A write enable
// modport master : the loader side (consumes the stream, drives the RAM bus)
// modport slave  : the environment side (sample source and RAM)
// ---------------------------------------------------------------------------
interface fft_bitrev_loader_if #(
  parameter int LOG2N_MAX = 10,
  parameter int DATA_W    = 32
);
  logic [DATA_W-1:0]    i_s_data;
  logic                 i_s_valid;
  logic                 o_s_ready;
  logic [LOG2N_MAX-1:0] o_ram_addr;
  logic [DATA_W-1:0]    o_ram_data;
  logic                 o_ram_we;

  modport master (
    input  i_s_data, i_s_valid,
    output o_s_ready, o_ram_addr, o_ram_data, o_ram_we
  );

  modport slave (
    output i_s_data, i_s_valid,
    input  o_s_ready, o_ram_addr, o_ram_data, o_ram_we
  );
endinterface

// File: rtl/fft_bitrev_loader.sv
// ---------------------------------------------------------------------------
// fft_bitrev_loader
// Input stage of the FFT datapath. Accepts a frame of N = 2^k complex samples
// over a valid/ready stream and writes sample n to RAM address bitrev_k(n), so
// the in-place butterfly engine produces naturally ordered output. After the
// frame is resident the block holds off input until the FFT core releases the
// RAM with i_fft_done.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : start a frame (honoured only when idle)
//   i_log2n        : transform size exponent, clamped to [3, LOG2N_MAX]
//   bus            : stream input + RAM port A write bus (master modport)
//   o_busy         : high while loading or holding a frame
//   o_frame_done   : one-cycle pulse once the last RAM write has committed
//   i_fft_done     : FFT core finished with the RAM; returns the block to idle
// ---------------------------------------------------------------------------
module fft_bitrev_loader #(
  parameter int LOG2N_MAX = 10,
  parameter int DATA_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [3:0]          i_log2n,
  fft_bitrev_loader_if.master bus,
  output logic                o_busy,
  output logic                o_frame_done,
  input  logic                i_fft_done
);

  localparam logic [3:0]         K_MIN   = 4'd3;
  localparam logic [3:0]         K_MAX   = LOG2N_MAX[3:0];
  localparam logic [LOG2N_MAX:0] CNT_ONE = {{LOG2N_MAX{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t               r_state;
  logic [LOG2N_MAX:0]   r_count;
  logic [3:0]           r_k;
  logic                 r_s_ready;
  logic                 r_ram_we;
  logic [LOG2N_MAX-1:0] r_ram_addr;
  logic [DATA_W-1:0]    r_ram_data;
  logic                 r_busy;
  logic                 r_frame_done;

  logic [3:0]           w_k_clamped;
  logic [LOG2N_MAX:0]   w_last_idx;
  logic [LOG2N_MAX-1:0] w_rev_full;
  logic [LOG2N_MAX-1:0] w_rev_addr;
  logic                 w_xfer;

  always_comb begin
    w_k_clamped = i_log2n;
    if (i_log2n < K_MIN)
      w_k_clamped = K_MIN;
    else if (i_log2n > K_MAX)
      w_k_clamped = K_MAX;
  end

  // Index of the final sample of the frame, N-1.
  assign w_last_idx = (CNT_ONE << r_k) - CNT_ONE;

  // Reverse all LOG2N_MAX counter bits, then shift right so only the low k
  // bits survive reversed: bit j ends up as counter bit (k-1-j), upper bits 0.
  for (genvar gi = 0; gi < LOG2N_MAX; gi++) begin : g_rev
    assign w_rev_full[gi] = r_count[LOG2N_MAX-1-gi];
  end
  assign w_rev_addr = w_rev_full >> (K_MAX - r_k);

  // r_s_ready is only ever set in LOAD, so it alone qualifies the transfer.
  assign w_xfer = bus.i_s_valid && r_s_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_k          <= K_MIN;
      r_s_ready    <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_ram_we     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_k       <= w_k_clamped;
            r_count   <= '0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_ram_we   <= 1'b1;
            r_ram_data <= bus.i_s_data;
            r_ram_addr <= w_rev_addr;
            r_count    <= r_count + CNT_ONE;
            if (r_count == w_last_idx) begin
              r_s_ready <= 1'b0;
              r_state   <= HOLD;
            end
          end
        end
        HOLD: begin
          // The last write is on the bus during the first HOLD cycle; the
          // done pulse follows it so the frame is committed when it fires.
          r_frame_done <= r_ram_we;
          if (i_fft_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_s_ready  = r_s_ready;
  assign bus.o_ram_we   = r_ram_we;
  assign bus.o_ram_addr = r_ram_addr;
  assign bus.o_ram_data = r_ram_data;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_loader
// Directed bench for fft_bitrev_loader: frames of several sizes, gapped
// valid, size clamping, ignored mid-frame start, HOLD behaviour and a
// mid-frame reset. Writes and frame-done pulses are logged on the falling
// edge and compared against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_loader;
  localparam int LOG2N_MAX = 10;
  localparam int DATA_W    = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] log2n;
  logic       fft_done;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  fft_bitrev_loader_if #(.LOG2N_MAX(LOG2N_MAX), .DATA_W(DATA_W)) bus ();

  fft_bitrev_loader #(.LOG2N_MAX(LOG2N_MAX), .DATA_W(DATA_W)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_log2n      (log2n),
    .bus          (bus.master),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .i_fft_done   (fft_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          xf_cyc[$];
  int          fd_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // A transfer seen here is sampled at the next rising edge (cycle cyc+1);
  // its write must then be visible at the falling edge of that same cycle.
  always @(negedge clk) begin
    if (bus.o_ram_we) begin
      wr_addr.push_back(32'(bus.o_ram_addr));
      wr_data.push_back(bus.o_ram_data);
      wr_cyc.push_back(cyc);
      $display("[TB] cyc %0d write addr=%0d data=0x%08h", cyc, bus.o_ram_addr, bus.o_ram_data);
    end
    if (bus.i_s_valid && bus.o_s_ready) xf_cyc.push_back(cyc + 1);
    if (frame_done) begin
      fd_cyc.push_back(cyc);
      $display("[TB] cyc %0d frame_done", cyc);
    end
  end

  function automatic int bitrev(input int v, input int k);
    int r;
    r = 0;
    for (int j = 0; j < k; j++)
      if (v[k-1-j]) r = r | (1 << j);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    xf_cyc.delete();
    fd_cyc.delete();
  endtask

  // pattern 0: back-to-back valid; pattern 1: valid 1,0,0,1,0,0,...
  task automatic run_frame(input string tag, input int log2n_in, input int n_exp,
                           input int pattern, input bit mid_start, input int hold_cycles);
    int sent, phase, budget, k_eff, n_cmp;
    int ea, ed, el;
    bit will;
    int exp_a8[8];
    exp_a8 = '{0, 4, 2, 6, 1, 5, 3, 7};
    sent = 0; phase = 0; budget = 0;
    ea = 0; ed = 0; el = 0;
    k_eff = $clog2(n_exp);
    clear_logs();

    start = 1'b1; log2n = 4'(log2n_in);
    step();
    start = 1'b0; log2n = 4'd0;

    while (sent < n_exp && budget < 5000) begin
      bus.i_s_valid = (pattern == 0) ? 1'b1 : ((phase % 3) == 0);
      bus.i_s_data  = 32'(sent + 1) << 16;
      if (mid_start && sent == 3) begin
        start = 1'b1; log2n = 4'd10;
      end else begin
        start = 1'b0; log2n = 4'd0;
      end
      will = bus.i_s_valid && bus.o_s_ready;
      step();
      if (will) sent++;
      phase++;
      budget++;
    end
    start = 1'b0;
    check({tag, "_samples_sent"}, 64'(sent), 64'(n_exp));
    check({tag, "_ready_after_last"}, 64'(bus.o_s_ready), 64'd0);

    // Keep offering samples through HOLD; none may be accepted or written.
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = 32'hDEAD_0000;
    repeat (hold_cycles + 3) step();
    bus.i_s_valid = 1'b0;

    check({tag, "_write_count"}, 64'(wr_addr.size()), 64'(n_exp));
    check({tag, "_xfer_count"}, 64'(xf_cyc.size()), 64'(n_exp));
    n_cmp = (wr_addr.size() < n_exp) ? wr_addr.size() : n_exp;
    if (xf_cyc.size() < n_cmp) n_cmp = xf_cyc.size();
    for (int i = 0; i < n_cmp; i++) begin
      if (n_exp == 8) begin
        if (wr_addr[i] != 32'(exp_a8[i])) ea++;
      end else begin
        if (wr_addr[i] != 32'(bitrev(i, k_eff))) ea++;
      end
      if (wr_data[i] != (32'(i + 1) << 16)) ed++;
      if (wr_cyc[i] != xf_cyc[i]) el++;
    end
    check({tag, "_addr_errors"}, 64'(ea), 64'd0);
    check({tag, "_data_errors"}, 64'(ed), 64'd0);
    check({tag, "_latency_errors"}, 64'(el), 64'd0);
    if (n_exp == 1024 && wr_addr.size() == 1024) begin
      check({tag, "_addr_of_sample1"}, 64'(wr_addr[1]), 64'd512);
      check({tag, "_addr_of_sample1023"}, 64'(wr_addr[1023]), 64'd1023);
    end
    check({tag, "_done_pulses"}, 64'(fd_cyc.size()), 64'd1);
    if (fd_cyc.size() >= 1 && xf_cyc.size() >= 1)
      check({tag, "_done_cycle"}, 64'(fd_cyc[0]), 64'(xf_cyc[xf_cyc.size()-1] + 1));
    check({tag, "_busy_in_hold"}, 64'(busy), 64'd1);

    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check({tag, "_busy_after_release"}, 64'(busy), 64'd0);
    check({tag, "_ready_after_release"}, 64'(bus.o_s_ready), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.o_s_ready), 64'd0);
    check({tag, "_we"}, 64'(bus.o_ram_we), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(frame_done), 64'd0);
    check({tag, "_addr"}, 64'(bus.o_ram_addr), 64'd0);
    check({tag, "_data"}, 64'(bus.o_ram_data), 64'd0);
  endtask

  initial begin
    int sent;
    rst = 1'b1; start = 1'b0; log2n = 4'd0; fft_done = 1'b0;
    bus.i_s_valid = 1'b0; bus.i_s_data = '0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    run_frame("k3_b2b",    3,  8,    0, 1'b0, 0);
    run_frame("k3_gap",    3,  8,    1, 1'b0, 0);
    run_frame("k10",       10, 1024, 0, 1'b0, 0);
    run_frame("k1_clamp",  1,  8,    0, 1'b0, 0);
    run_frame("k15_clamp", 15, 1024, 0, 1'b0, 0);
    run_frame("mid_start", 3,  8,    0, 1'b1, 0);
    run_frame("hold20",    3,  8,    0, 1'b0, 20);
    run_frame("k4_second", 4,  16,   0, 1'b0, 0);

    // Abandon a frame after 5 of 8 samples.
    clear_logs();
    start = 1'b1; log2n = 4'd3;
    step();
    start = 1'b0;
    sent = 0;
    for (int b = 0; b < 50 && sent < 5; b++) begin
      bus.i_s_valid = 1'b1;
      bus.i_s_data  = 32'(sent + 1) << 16;
      if (bus.o_s_ready) begin
        step();
        sent++;
      end else begin
        step();
      end
    end
    bus.i_s_valid = 1'b0;
    check("midrst_samples_sent", 64'(sent), 64'd5);
    rst = 1'b1;
    step();
    check_outputs_zero("midrst");
    rst = 1'b0;
    repeat (4) step();
    check("midrst_no_done", 64'(fd_cyc.size()), 64'd0);
    check("midrst_busy_idle", 64'(busy), 64'd0);

    run_frame("after_rst", 3, 8, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
